// File: rtl/counter_sched_if.sv
// Command handshake bundle for the dual-counter sequencer.
// The host drives the command fields; the sequencer returns cmd_ready.
interface counter_sched_if #(
    parameter int ARG_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_sel;
    logic [ARG_W-1:0] cmd_arg;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sched.sv
// Command sequencer driving enable/load of an 8-bit and a 16-bit counter.
// Optional abort input enabled by defining COUNTER_SCHED_ABORT_EN.
module counter_sched #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 16,
    parameter int ARG_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    counter_sched_if.slave     cmd,
    output logic               en_a,
    output logic               en_b,
    output logic               load_a,
    output logic               load_b,
    output logic [WIDTH_A-1:0] load_val_a,
    output logic [WIDTH_B-1:0] load_val_b,
    input  logic               ovf_a,
    input  logic               ovf_b,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [1:0]         status
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_RUN_OVF, S_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_OVF = 2'd1;
    localparam logic [1:0] ST_TMO = 2'd2;
    localparam logic [1:0] ST_ABT = 2'd3;

    state_t           state, state_n;
    logic             sel, sel_n;
    logic [ARG_W-1:0] rem, rem_n;
    logic [1:0]       status_n;
    logic             accept, arg_zero, ovf_sel, ovf_cmd;
    logic             abort_hit, en_sel, ld_sel;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign arg_zero = (cmd.cmd_arg == '0);
    assign ovf_sel  = sel ? ovf_b : ovf_a;
    assign ovf_cmd  = cmd.cmd_sel ? ovf_b : ovf_a;

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort_hit = abort && (state == S_RUN ||
                                 state == S_RUN_OVF ||
                                 state == S_WAIT);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel    <= 1'b0;
            rem    <= '0;
            status <= ST_OK;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            rem    <= rem_n;
            status <= status_n;
        end
    end

    // Load values change on accept so they are stable throughout LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_val_a <= '0;
            load_val_b <= '0;
        end else if (accept && cmd.cmd_op == 2'd0) begin
            if (cmd.cmd_sel) load_val_b <= cmd.cmd_arg[WIDTH_B-1:0];
            else             load_val_a <= cmd.cmd_arg[WIDTH_A-1:0];
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        rem_n    = rem;
        status_n = status;
        en_sel   = 1'b0;
        ld_sel   = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    sel_n = cmd.cmd_sel;
                    rem_n = cmd.cmd_arg;
                    unique case (cmd.cmd_op)
                        2'd0: state_n = S_LOAD;
                        2'd1: begin
                            state_n = arg_zero ? S_DONE : S_RUN;
                            if (arg_zero) status_n = ST_OK;
                        end
                        2'd2: begin
                            state_n = arg_zero ? S_DONE : S_RUN_OVF;
                            if (arg_zero) status_n = ovf_cmd ? ST_OVF : ST_TMO;
                        end
                        default: begin
                            state_n = arg_zero ? S_DONE : S_WAIT;
                            if (arg_zero) status_n = ST_OK;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                ld_sel   = 1'b1;
                state_n  = S_DONE;
                status_n = ST_OK;
            end
            S_RUN: begin
                en_sel = 1'b1;
                rem_n  = rem - 1'b1;
                if (rem == 1) begin
                    state_n  = S_DONE;
                    status_n = ST_OK;
                end
            end
            S_RUN_OVF: begin
                en_sel = !ovf_sel;
                rem_n  = rem - 1'b1;
                if (ovf_sel) begin
                    state_n  = S_DONE;
                    status_n = ST_OVF;
                end else if (rem == 1) begin
                    state_n  = S_DONE;
                    status_n = ST_TMO;
                end
            end
            S_WAIT: begin
                rem_n = rem - 1'b1;
                if (rem == 1) begin
                    state_n  = S_DONE;
                    status_n = ST_OK;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort_hit) begin
            en_sel   = 1'b0;
            state_n  = S_DONE;
            status_n = ST_ABT;
        end
    end

    assign en_a   = en_sel && !sel;
    assign en_b   = en_sel && sel;
    assign load_a = ld_sel && !sel;
    assign load_b = ld_sel && sel;
endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched with a behavioural counter pair and command model.
// Define COUNTER_SCHED_ABORT_EN to also exercise the abort input.
module tb_counter_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a, en_b, load_a, load_b;
    logic [7:0]  load_val_a;
    logic [15:0] load_val_b;
    logic        ovf_a, ovf_b;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [1:0]  status;
    logic [7:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int ob_ena, ob_enb, ob_lda, ob_ldb, ob_lat, ob_st;
    int ob_ld_cyc, ob_lva, ob_lvb;

    counter_sched_if #(.ARG_W(16)) cif ();

    counter_sched dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cif),
        .en_a       (en_a),
        .en_b       (en_b),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_val_a (load_val_a),
        .load_val_b (load_val_b),
        .ovf_a      (ovf_a),
        .ovf_b      (ovf_b),
`ifdef COUNTER_SCHED_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Counter pair: load clears the sticky overflow, wrap sets it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0; ovf_a <= 1'b0;
            cnt_b <= '0; ovf_b <= 1'b0;
        end else begin
            if (load_a) begin
                cnt_a <= load_val_a; ovf_a <= 1'b0;
            end else if (en_a) begin
                cnt_a <= cnt_a + 8'd1;
                if (cnt_a == 8'hFF) ovf_a <= 1'b1;
            end
            if (load_b) begin
                cnt_b <= load_val_b; ovf_b <= 1'b0;
            end else if (en_b) begin
                cnt_b <= cnt_b + 16'd1;
                if (cnt_b == 16'hFFFF) ovf_b <= 1'b1;
            end
        end
    end

    // Expected enable cycles, done latency after accept, and status.
    function automatic void predict(input int op, input int arg,
                                    input int c, input bit f,
                                    input int maxv, output int en_n,
                                    output int lat, output int st);
        int s;
        s = maxv + 1 - c;
        case (op)
            0: begin en_n = 0; lat = 2; st = 0; end
            1: begin en_n = arg; lat = arg + 1; st = 0; end
            3: begin en_n = 0; lat = arg + 1; st = 0; end
            default: begin
                if (arg == 0) begin
                    en_n = 0; lat = 1; st = f ? 1 : 2;
                end else if (f) begin
                    en_n = 0; lat = 2; st = 1;
                end else if (s < arg) begin
                    en_n = s; lat = s + 2; st = 1;
                end else begin
                    en_n = arg; lat = arg + 1; st = 2;
                end
            end
        endcase
    endfunction

    // Issues one command and records what happened until done (or bound).
    task automatic send_cmd(input logic [1:0] op, input logic sel,
                            input logic [15:0] arg, input int abort_at);
        int n;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_sel   = sel;
        cif.cmd_arg   = arg;
        n = 0;
        while (!cif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cif.cmd_valid = 1'b0;
        ob_ena = 0; ob_enb = 0; ob_lda = 0; ob_ldb = 0;
        ob_lat = -1; ob_st = -1; ob_ld_cyc = -1; ob_lva = -1; ob_lvb = -1;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            abort = (abort_at != 0 && c == abort_at);
            @(negedge clk);
            ob_ena += int'(en_a);
            ob_enb += int'(en_b);
            if (load_a) begin
                ob_lda++; ob_ld_cyc = c; ob_lva = int'(load_val_a);
            end
            if (load_b) begin
                ob_ldb++; ob_ld_cyc = c; ob_lvb = int'(load_val_b);
            end
            if (done) begin
                ob_lat = c; ob_st = int'(status);
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cif.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got ready=%b busy=%b done=%b exp 1 0 0",
                     cif.cmd_ready, busy, done);
        end
        checks++;
        if ({en_a, en_b, load_a, load_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000",
                     {en_a, en_b, load_a, load_b});
        end
        checks++;
        if (load_val_a !== 8'h00 || load_val_b !== 16'h0000 || status !== 2'd0) begin
            errors++;
            $display("FAIL reset_vals got a=%h b=%h st=%0d exp 0 0 0",
                     load_val_a, load_val_b, status);
        end
    endtask

    task automatic test_load;
        send_cmd(2'd0, 1'b0, 16'h1234, 0);
        checks++;
        if (ob_ld_cyc !== 1 || ob_lda !== 1 || ob_ldb !== 0) begin
            errors++;
            $display("FAIL load_pulse got cyc=%0d a=%0d b=%0d exp 1 1 0",
                     ob_ld_cyc, ob_lda, ob_ldb);
        end
        checks++;
        if (ob_lva !== 32'h34) begin
            errors++;
            $display("FAIL load_val got %h exp 34", ob_lva);
        end
        checks++;
        if (ob_lat !== 2 || ob_st !== 0) begin
            errors++;
            $display("FAIL load_done got lat=%0d st=%0d exp 2 0", ob_lat, ob_st);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (load_val_a !== 8'h34 || cnt_a !== 8'h34) begin
            errors++;
            $display("FAIL load_hold got val=%h cnt=%h exp 34 34",
                     load_val_a, cnt_a);
        end
    endtask

    task automatic test_run;
        send_cmd(2'd0, 1'b1, 16'hFFFE, 0);
        send_cmd(2'd1, 1'b1, 16'd5, 0);
        checks++;
        if (ob_enb !== 5 || ob_ena !== 0) begin
            errors++;
            $display("FAIL run_en got b=%0d a=%0d exp 5 0", ob_enb, ob_ena);
        end
        checks++;
        if (ob_lat !== 6 || ob_st !== 0) begin
            errors++;
            $display("FAIL run_done got lat=%0d st=%0d exp 6 0", ob_lat, ob_st);
        end
        checks++;
        if (cnt_b !== 16'h0003) begin
            errors++;
            $display("FAIL run_cnt got %h exp 0003", cnt_b);
        end
    endtask

    task automatic test_run_ovf;
        send_cmd(2'd0, 1'b0, 16'h00FD, 0);
        send_cmd(2'd2, 1'b0, 16'd100, 0);
        checks++;
        if (ob_ena !== 3 || ob_enb !== 0) begin
            errors++;
            $display("FAIL ovf_en got a=%0d b=%0d exp 3 0", ob_ena, ob_enb);
        end
        checks++;
        if (ob_lat !== 5 || ob_st !== 1) begin
            errors++;
            $display("FAIL ovf_done got lat=%0d st=%0d exp 5 1", ob_lat, ob_st);
        end
        checks++;
        if (cnt_a !== 8'h00 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_cnt got cnt=%h ovf=%b exp 00 1", cnt_a, ovf_a);
        end
    endtask

    task automatic test_boundaries;
        send_cmd(2'd2, 1'b0, 16'd10, 0);
        checks++;
        if (ob_ena !== 0 || ob_lat !== 2 || ob_st !== 1) begin
            errors++;
            $display("FAIL preset_ovf got en=%0d lat=%0d st=%0d exp 0 2 1",
                     ob_ena, ob_lat, ob_st);
        end
        send_cmd(2'd1, 1'b0, 16'd0, 0);
        checks++;
        if (ob_ena !== 0 || ob_lat !== 1 || ob_st !== 0) begin
            errors++;
            $display("FAIL run_zero got en=%0d lat=%0d st=%0d exp 0 1 0",
                     ob_ena, ob_lat, ob_st);
        end
        send_cmd(2'd3, 1'b1, 16'd4, 0);
        checks++;
        if (ob_enb !== 0 || ob_ena !== 0 || ob_lat !== 5 || ob_st !== 0) begin
            errors++;
            $display("FAIL wait got en=%0d/%0d lat=%0d st=%0d exp 0 0 5 0",
                     ob_ena, ob_enb, ob_lat, ob_st);
        end
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'd1;
        cif.cmd_sel   = 1'b1;
        cif.cmd_arg   = 16'd20;
        @(posedge clk);
        #1 cif.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (en_b !== 1'b1) begin
            errors++;
            $display("FAIL mid_en got %b exp 1", en_b);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (en_b !== 1'b0 || busy !== 1'b0 || cif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async got en=%b busy=%b ready=%b exp 0 0 1",
                     en_b, busy, cif.cmd_ready);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done |= done;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_done |= done;
        end
        checks++;
        if (seen_done !== 1'b0 || cif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release got done=%b ready=%b exp 0 1",
                     seen_done, cif.cmd_ready);
        end
        send_cmd(2'd1, 1'b1, 16'd4, 0);
        checks++;
        if (ob_enb !== 4 || ob_lat !== 5 || ob_st !== 0) begin
            errors++;
            $display("FAIL mid_next got en=%0d lat=%0d st=%0d exp 4 5 0",
                     ob_enb, ob_lat, ob_st);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic        sel;
        logic [15:0] arg;
        int c, maxv, e_en, e_lat, e_st, en_sel, en_oth;
        bit f;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = 1'($urandom_range(0, 1));
            if (op == 2'd0) begin
                arg = 16'($urandom);
                if ($urandom_range(0, 3) != 0)
                    arg = arg | (sel ? 16'hFFF0 : 16'h00F0);
            end else begin
                arg = 16'($urandom_range(0, 24));
            end
            c    = sel ? int'(cnt_b) : int'(cnt_a);
            f    = sel ? ovf_b : ovf_a;
            maxv = sel ? 65535 : 255;
            predict(int'(op), int'(arg), c, f, maxv, e_en, e_lat, e_st);
            send_cmd(op, sel, arg, 0);
            en_sel = sel ? ob_enb : ob_ena;
            en_oth = sel ? ob_ena : ob_enb;
            checks++;
            if (en_sel !== e_en || en_oth !== 0) begin
                errors++;
                $display("FAIL rnd%0d_en op=%0d got %0d/%0d exp %0d/0",
                         i, op, en_sel, en_oth, e_en);
            end
            checks++;
            if (ob_lat !== e_lat || ob_st !== e_st) begin
                errors++;
                $display("FAIL rnd%0d_done op=%0d arg=%0d got lat=%0d st=%0d exp %0d %0d",
                         i, op, arg, ob_lat, ob_st, e_lat, e_st);
            end
            if (op == 2'd0) begin
                checks++;
                if ((sel ? ob_ldb : ob_lda) !== 1 || (sel ? ob_lda : ob_ldb) !== 0) begin
                    errors++;
                    $display("FAIL rnd%0d_load got a=%0d b=%0d sel=%0d",
                             i, ob_lda, ob_ldb, sel);
                end
            end
            if (op == 2'd1) begin
                checks++;
                if ((sel ? int'(cnt_b) : int'(cnt_a)) !== ((c + e_en) % (maxv + 1))) begin
                    errors++;
                    $display("FAIL rnd%0d_cnt got %0d exp %0d", i,
                             sel ? int'(cnt_b) : int'(cnt_a),
                             (c + e_en) % (maxv + 1));
                end
            end
        end
    endtask

`ifdef COUNTER_SCHED_ABORT_EN
    task automatic test_abort;
        send_cmd(2'd1, 1'b0, 16'd50, 4);
        checks++;
        if (ob_ena !== 3 || ob_lat !== 5 || ob_st !== 3) begin
            errors++;
            $display("FAIL abort got en=%0d lat=%0d st=%0d exp 3 5 3",
                     ob_ena, ob_lat, ob_st);
        end
    endtask
`endif

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'd0;
        cif.cmd_sel   = 1'b0;
        cif.cmd_arg   = '0;
        test_reset;
        test_load;
        test_run;
        test_run_ovf;
        test_boundaries;
        test_reset_mid;
`ifdef COUNTER_SCHED_ABORT_EN
        test_abort;
`endif
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Command-driven sequencer for the dual-counter block (8-bit counter A, 16-bit counter B).
- Accepts one command at a time over a valid/ready interface and drives that block's enable, load and load-value inputs.
- Watches the counters' sticky overflow outputs and reports completion with a status code.
- Sits between the scan-test host and the counter pair so scan capture and restore can be exercised at known counter states.

Parameters:
- WIDTH_A, 8, width of counter A load value.
- WIDTH_B, 16, width of counter B load value.
- ARG_W, 16, width of command argument and internal cycle counter; must be >= max(WIDTH_A, WIDTH_B).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  2  0=LOAD, 1=RUN, 2=RUN_OVF, 3=WAIT
- cmd_sel  in  1  target counter: 0=A, 1=B
- cmd_arg  in  ARG_W  load value (LOAD) or cycle count (RUN/RUN_OVF/WAIT)
- en_a, en_b  out  1  counter enables
- load_a, load_b  out  1  counter load strobes
- load_val_a  out  WIDTH_A  counter A load value
- load_val_b  out  WIDTH_B  counter B load value
- ovf_a, ovf_b  in  1  sticky overflow flags from the counters
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- status  out  2  valid with done: 0=OK, 1=OVF_HIT, 2=TIMEOUT

Behaviour:
- Reset values: state IDLE; en_*, load_*, done, busy = 0; load_val_* = 0; status = 0; cmd_ready = 1.
- Reset mid-command: immediate return to IDLE; en/load drop; no done pulse.
- States: IDLE, LOAD, RUN, RUN_OVF, WAIT, DONE.
- cmd_ready = (state == IDLE). Command fields are latched on accept; the next state is entered on the next cycle. The latched cycle counter rem is set to cmd_arg.
- LOAD:
  - load_<sel> = 1 for exactly one cycle, the cycle after accept.
  - load_val_<sel> = arg truncated to that width (LSBs).
  - Next state DONE, status OK.
  - load_val_* holds its last loaded value outside LOAD.
- RUN:
  - en_<sel> = 1 for exactly arg consecutive cycles, starting the cycle after accept; rem decrements each cycle.
  - When rem reaches 1 → DONE, status OK.
  - arg = 0 → straight to DONE, zero enable cycles.
- RUN_OVF:
  - en_<sel> = (state == RUN_OVF) && !ovf_<sel>. This is the only combinational input→output path.
  - Each cycle: if ovf_<sel> = 1 → DONE, status OVF_HIT, en low that cycle.
  - Else if rem == 1 (last enabled cycle) → DONE, status TIMEOUT.
  - Overflow already set at entry → zero enable cycles, status OVF_HIT.
  - arg = 0 with no overflow → DONE, status TIMEOUT, zero enables.
- WAIT: no outputs asserted for arg cycles (arg = 0 → immediate), then DONE, status OK.
- DONE: done = 1 for one cycle; status is registered and held until the next done. Then IDLE.
- Minimum command spacing: N + 2 cycles for RUN/WAIT; LOAD is 3 cycles accept-to-ready.
- Only the selected counter's en/load is ever asserted; the other stays 0.
- Illegal combinations: none; every op/sel pair is legal.

Optional Feature:
- Macro: COUNTER_SCHED_ABORT_EN. Adds input port abort (1 bit).
- With macro: abort = 1 in RUN, RUN_OVF or WAIT → next cycle DONE with status 3 (ABORTED), en deasserted in the same cycle abort is seen (combinational). abort in IDLE, LOAD or DONE is ignored.
- Without macro: no abort port; status value 3 is never produced.

Test Plan:
- Reset, then LOAD sel=0 arg=0x1234 → load_a one cycle after accept with load_val_a=0x34; done two cycles after accept, status=0; load_b never asserted.
- LOAD B 0xFFFE, then RUN sel=1 arg=5 → en_b high exactly 5 cycles; done, status 0; counter B count = 0x0003.
- LOAD A 0xFD, then RUN_OVF sel=0 arg=100 → en_a high 3 cycles; done with status 1; count_a = 0x00.
- RUN_OVF A arg=10 while ovf_a already 1 → en_a never asserted; done the cycle after DONE entry, status 1. RUN A arg=0 → no enable, done, status 0.
- RUN B arg=20, assert rst at cycle 7 → en_b drops asynchronously, no done pulse, cmd_ready=1 after reset release; the next command is accepted normally.
- With COUNTER_SCHED_ABORT_EN: RUN A arg=50, abort at enable cycle 4 → en_a low from that cycle, done next cycle, status 3; exactly 3 enable cycles counted.
